crowd_direction_detector: RTL and testbench

Upstream stage of the occupancy counter. Consumes the two asynchronous presence pulses from the outer (ECHO1) and inner (ECHO2) ultrasonic channels and decides the crossing direction. Emits a single-cycle ENTRY_PULSE (ECHO1 then ECHO2) or EXIT_PULSE (ECHO2 then ECHO1), which the capacity counter/buzzer logic consumes. Abandoned half-crossings are discarded by a timeout, and a hold-off window after each decision suppresses retriggers.

---
 rtl/crowd_pkg.sv | 24 ++
 rtl/crowd_direction_detector_if.sv | 22 ++
 rtl/crowd_direction_detector_sync_rise_detect.sv | 31 +++
 rtl/crowd_direction_detector.sv | 125 ++++++++++++
 tb/tb_crowd_direction_detector.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/crowd_pkg.sv
// Shared definitions for the crowd direction detector: FSM encodings, clock
// frequency and default timing constants.
package crowd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEN1   = 2'd1,
        SEEN2   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    localparam int CLK_HZ          = 50000000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 25000000;
    localparam int DEF_HOLDOFF_CYC = 1000;

    // Width of a down-counter that must hold max(a, b) - 1; never below one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/crowd_direction_detector_if.sv
// Sensor inputs and decision outputs of the crowd direction detector.
interface crowd_direction_detector_if;
    import crowd_pkg::*;

    logic       ECHO1;
    logic       ECHO2;
    logic       ENTRY_PULSE;
    logic       EXIT_PULSE;
    logic       TIMEOUT_PULSE;
    logic [1:0] STATE;

    modport master (
        output ECHO1, ECHO2,
        input  ENTRY_PULSE, EXIT_PULSE, TIMEOUT_PULSE, STATE
    );

    modport slave (
        input  ECHO1, ECHO2,
        output ENTRY_PULSE, EXIT_PULSE, TIMEOUT_PULSE, STATE
    );

endinterface

// File: rtl/crowd_direction_detector_sync_rise_detect.sv
// Multi-flop synchronizer for one asynchronous echo line followed by a
// rising-edge detector on the synchronized value.
module sync_rise_detect
    import crowd_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_p0 <= '0;
            prev_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
            prev_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_p0[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_p1;

endmodule

// File: rtl/crowd_direction_detector.sv
// Decides crossing direction from the order of outer/inner sensor edges and
// emits one-cycle entry, exit or abandoned-crossing strobes.
module crowd_direction_detector
    import crowd_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC
) (
    input  logic                          CLOCK_50,
    input  logic                          RESET_N,
    crowd_direction_detector_if.slave     bus
);

    localparam int TW = timer_width(TIMEOUT_CYC, HOLDOFF_CYC);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] HOLDOFF_LOAD = TW'(HOLDOFF_CYC - 1);

    logic    sync1, sync2, rise1, rise2;
    logic    unused_sync;
    state_t  state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic    entry, entry_nxt;
    logic    exit_s, exit_nxt;
    logic    timeout, timeout_nxt;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .async_in (bus.ECHO1),
        .sync_out (sync1),
        .rise     (rise1)
    );

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .async_in (bus.ECHO2),
        .sync_out (sync2),
        .rise     (rise2)
    );

    assign unused_sync = sync1 ^ sync2;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            timer   <= '0;
            entry   <= 1'b0;
            exit_s  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            entry   <= entry_nxt;
            exit_s  <= exit_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        entry_nxt   = 1'b0;
        exit_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                // Both sensors rising together gives no direction; ignore it.
                if (rise1 && !rise2) begin
                    state_nxt = SEEN1;
                    timer_nxt = TIMEOUT_LOAD;
                end else if (rise2 && !rise1) begin
                    state_nxt = SEEN2;
                    timer_nxt = TIMEOUT_LOAD;
                end
            end
            SEEN1: begin
                if (rise2) begin
                    entry_nxt = 1'b1;
                    state_nxt = HOLDOFF;
                    timer_nxt = HOLDOFF_LOAD;
                end else if (rise1) begin
                    timer_nxt = TIMEOUT_LOAD;
                end else if (timer == '0) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            SEEN2: begin
                if (rise1) begin
                    exit_nxt  = 1'b1;
                    state_nxt = HOLDOFF;
                    timer_nxt = HOLDOFF_LOAD;
                end else if (rise2) begin
                    timer_nxt = TIMEOUT_LOAD;
                end else if (timer == '0) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            HOLDOFF: begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    assign bus.ENTRY_PULSE   = entry;
    assign bus.EXIT_PULSE    = exit_s;
    assign bus.TIMEOUT_PULSE = timeout;
    assign bus.STATE         = state;

endmodule

// File: tb/tb_crowd_direction_detector.sv
// Directed scoreboard bench for crowd_direction_detector with shortened timing.
module tb_crowd_direction_detector;

    localparam int SYNC    = 2;
    localparam int TOUT    = 5000;
    localparam int HOLD    = 1000;
    localparam int LAT     = SYNC + 1;
    localparam int K_ENTRY = 0;
    localparam int K_EXIT  = 1;
    localparam int K_TOUT  = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   rd;
    int   multi_hot;
    ev_t  exp_q[$];
    int   obs_kind[$];
    int   obs_cyc[$];

    crowd_direction_detector_if bus ();

    crowd_direction_detector #(
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TOUT),
        .HOLDOFF_CYC (HOLD)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Record every strobe with the cycle in which it appeared.
    initial multi_hot = 0;
    always @(negedge clk) begin
        if (rst_n && (bus.ENTRY_PULSE || bus.EXIT_PULSE || bus.TIMEOUT_PULSE)) begin
            if (int'(bus.ENTRY_PULSE) + int'(bus.EXIT_PULSE) + int'(bus.TIMEOUT_PULSE) > 1)
                multi_hot = multi_hot + 1;
            obs_kind.push_back(bus.ENTRY_PULSE ? K_ENTRY : (bus.EXIT_PULSE ? K_EXIT : K_TOUT));
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // first_outer=1: ECHO1 then ECHO2 (entry); 0: ECHO2 then ECHO1 (exit).
    task automatic do_cross(input bit first_outer, input int gap);
        if (first_outer) bus.ECHO1 = 1'b1; else bus.ECHO2 = 1'b1;
        wait_n(50);
        bus.ECHO1 = 1'b0;
        bus.ECHO2 = 1'b0;
        wait_n(gap);
        push_ev(first_outer ? K_ENTRY : K_EXIT, cyc + LAT);
        if (first_outer) bus.ECHO2 = 1'b1; else bus.ECHO1 = 1'b1;
        wait_n(50);
        bus.ECHO1 = 1'b0;
        bus.ECHO2 = 1'b0;
    endtask

    task automatic drain(input string tag);
        ev_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_present"}, (obs_kind.size() > rd) ? 1 : 0, 1);
            if (obs_kind.size() > rd) begin
                chk({tag, "_kind"}, obs_kind[rd], e.kind);
                chk({tag, "_cycle"}, obs_cyc[rd], e.cyc);
                rd++;
            end
        end
        chk({tag, "_no_extra"}, obs_kind.size(), rd);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rd    = 0;
        rst_n = 1'b0;
        bus.ECHO1 = 1'b0;
        bus.ECHO2 = 1'b0;
        wait_n(3);
        chk("rst_state",   int'(bus.STATE), 0);
        chk("rst_entry",   int'(bus.ENTRY_PULSE), 0);
        chk("rst_exit",    int'(bus.EXIT_PULSE), 0);
        chk("rst_timeout", int'(bus.TIMEOUT_PULSE), 0);
        rst_n = 1'b1;
        wait_n(5);

        // 1: single entry, then hold-off and return to idle
        do_cross(1'b1, 2500);
        wait_n(5);
        chk("s1_holdoff", int'(bus.STATE), 3);
        wait_n(1100);
        chk("s1_idle", int'(bus.STATE), 0);
        drain("s1");

        // 2: single exit, then a run of back-to-back entries
        do_cross(1'b0, 2500);
        wait_n(1150);
        drain("s2_exit");
        for (int i = 0; i < 10; i++) begin
            do_cross(1'b1, 300);
            wait_n(1000);
        end
        drain("s2_burst");

        // 3: lone outer edge times out
        push_ev(K_TOUT, cyc + LAT + TOUT);
        bus.ECHO1 = 1'b1;
        wait_n(50);
        bus.ECHO1 = 1'b0;
        wait_n(50);
        chk("s3_seen1", int'(bus.STATE), 1);
        wait_n(5100);
        chk("s3_idle", int'(bus.STATE), 0);
        drain("s3");

        // 4: simultaneous rise is ambiguous
        bus.ECHO1 = 1'b1;
        bus.ECHO2 = 1'b1;
        wait_n(10);
        chk("s4_state", int'(bus.STATE), 0);
        wait_n(40);
        bus.ECHO1 = 1'b0;
        bus.ECHO2 = 1'b0;
        wait_n(10);
        chk("s4_state_after", int'(bus.STATE), 0);
        drain("s4");

        // 5: edge inside hold-off ignored, later exit still detected
        do_cross(1'b1, 300);
        wait_n(150);
        bus.ECHO2 = 1'b1;
        wait_n(50);
        bus.ECHO2 = 1'b0;
        wait_n(20);
        chk("s5_holdoff", int'(bus.STATE), 3);
        wait_n(1000);
        chk("s5_idle", int'(bus.STATE), 0);
        do_cross(1'b0, 300);
        wait_n(1100);
        drain("s5");

        // 6: reset in SEEN1 forgets the pending crossing
        bus.ECHO1 = 1'b1;
        wait_n(50);
        bus.ECHO1 = 1'b0;
        wait_n(50);
        chk("s6_seen1", int'(bus.STATE), 1);
        rst_n = 1'b0;
        wait_n(1);
        chk("s6_rst_state", int'(bus.STATE), 0);
        chk("s6_rst_pulses", int'({bus.ENTRY_PULSE, bus.EXIT_PULSE, bus.TIMEOUT_PULSE}), 0);
        wait_n(4);
        rst_n = 1'b1;
        wait_n(5);
        push_ev(K_TOUT, cyc + LAT + TOUT);
        bus.ECHO2 = 1'b1;
        wait_n(50);
        bus.ECHO2 = 1'b0;
        wait_n(10);
        chk("s6_seen2", int'(bus.STATE), 2);
        wait_n(5100);
        chk("s6_idle", int'(bus.STATE), 0);
        drain("s6");

        chk("exclusive_pulses", multi_hot, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
